id_hazard_stage: RTL

ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

---
 rtl/id_hazard_stage_pkg.sv | 34 +++
 rtl/id_hazard_stage_units.sv | 164 ++++++++++++++++
 rtl/id_hazard_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/id_hazard_stage_pkg.sv
// Shared instruction-field types and RV32I opcode constants for the decode/hazard stage.
package id_hazard_stage_pkg;

    typedef logic [31:0] instruction;
    typedef logic [4:0]  regAddr;
    typedef logic [3:0]  ctrALU;
    typedef logic [3:0]  ctrBranch;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcodeT;

    // ALU control: {funct7[5], funct3} for arithmetic ops, ADD for address math
    localparam ctrALU ALU_ADD   = 4'b0000;
    localparam ctrALU ALU_PASSB = 4'b1111;

    // Branch control: conditional branches carry {1, funct3}
    localparam ctrBranch BR_NONE = 4'b0000;
    localparam ctrBranch BR_JAL  = 4'b0001;
    localparam ctrBranch BR_JALR = 4'b0010;

    function automatic logic isLoadOp(input instruction insn);
        return insn[6:0] == OP_LOAD;
    endfunction

endpackage

// File: rtl/id_hazard_stage_units.sv
// Building blocks of the decode stage: instruction Decoder, generic Mux and the load scoreboard.

module Decoder
    import id_hazard_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  instruction             insn,
    output logic                   regWe,
    output logic                   dataWe,
    output logic                   regSelect,
    output ctrBranch               branchCtr,
    output ctrALU                  aluCtr,
    output regAddr                 rs1,
    output regAddr                 rs2,
    output regAddr                 rd,
    output logic signed [XLEN-1:0] offset,
    output logic                   rs1Read,
    output logic                   rs2Read,
    output logic                   isLoad
);
    logic [2:0]         f3;
    logic signed [31:0] imm;

    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign rd     = insn[11:7];
    assign offset = XLEN'(imm);

    // Control fields and the format-specific sign-extended immediate per opcode
    always_comb begin
        regWe     = 1'b0;
        dataWe    = 1'b0;
        regSelect = 1'b0;
        branchCtr = BR_NONE;
        aluCtr    = ALU_ADD;
        imm       = '0;
        rs1Read   = 1'b1;
        rs2Read   = 1'b0;
        isLoad    = 1'b0;
        case (insn[6:0])
            OP_LUI: begin
                regWe   = 1'b1;
                aluCtr  = ALU_PASSB;
                rs1Read = 1'b0;
                imm     = {insn[31:12], 12'b0};
            end
            OP_AUIPC: begin
                regWe   = 1'b1;
                rs1Read = 1'b0;
                imm     = {insn[31:12], 12'b0};
            end
            OP_JAL: begin
                regWe     = 1'b1;
                branchCtr = BR_JAL;
                rs1Read   = 1'b0;
                imm       = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            OP_JALR: begin
                regWe     = 1'b1;
                branchCtr = BR_JALR;
                imm       = {{20{insn[31]}}, insn[31:20]};
            end
            OP_BRANCH: begin
                branchCtr = {1'b1, f3};
                rs2Read   = 1'b1;
                imm       = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            OP_LOAD: begin
                regWe     = 1'b1;
                regSelect = 1'b1;
                isLoad    = 1'b1;
                imm       = {{20{insn[31]}}, insn[31:20]};
            end
            OP_STORE: begin
                dataWe  = 1'b1;
                rs2Read = 1'b1;
                imm     = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OP_IMM: begin
                regWe  = 1'b1;
                aluCtr = {(f3 == 3'b101) && insn[30], f3};
                imm    = {{20{insn[31]}}, insn[31:20]};
            end
            OP_REG: begin
                regWe   = 1'b1;
                rs2Read = 1'b1;
                aluCtr  = {insn[30], f3};
            end
            default: begin
                regWe = 1'b0;
            end
        endcase
    end

endmodule

module Mux #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module load_scoreboard
    import id_hazard_stage_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int PCW         = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issueLoad,
    input  regAddr         issueRd,
    input  logic           wbValid,
    input  regAddr         wbRd,
    output logic [31:0]    pending,
    output logic [PCW-1:0] pendCnt,
    output logic           full
);
    logic           clrHit;
    logic           setLive;
    logic           setNew;
    logic [31:0]    clrMask;
    logic [31:0]    setMask;
    logic [31:0]    pendingNext;
    logic [PCW-1:0] cntNext;

    // A same-register set and clear nets to "still pending, count unchanged"
    always_comb begin
        clrHit      = wbValid && pending[wbRd];
        setLive     = issueLoad && (issueRd != '0);
        setNew      = setLive && (!pending[issueRd] || (clrHit && (wbRd == issueRd)));
        clrMask     = clrHit  ? (32'b1 << wbRd)    : '0;
        setMask     = setLive ? (32'b1 << issueRd) : '0;
        pendingNext = ((pending & ~clrMask) | setMask) & 32'hFFFF_FFFE;
        cntNext     = pendCnt;
        if (setNew && !clrHit) begin
            cntNext = pendCnt + PCW'(1);
        end else if (!setNew && clrHit) begin
            cntNext = pendCnt - PCW'(1);
        end
    end

    // Pending bitmap and outstanding-load count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            pendCnt <= '0;
        end else begin
            pending <= pendingNext;
            pendCnt <= cntNext;
        end
    end

    // >= so the one-over case (a load accepted just below the limit) still blocks
    assign full = pendCnt >= PCW'(MAX_PENDING);

endmodule

// File: rtl/id_hazard_stage.sv
// Decode stage with load-use hazard detection, a single-entry output bundle and stall statistics.
module id_hazard_stage
    import id_hazard_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  instruction             in_insn,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  regAddr                 wb_rd,
    output logic                   out_regWe,
    output logic                   out_dataWe,
    output logic                   out_regSelect,
    output ctrBranch               out_branchCtr,
    output ctrALU                  out_aluCtr,
    output regAddr                 out_regA,
    output regAddr                 out_regB,
    output regAddr                 out_rd,
    output logic signed [XLEN-1:0] out_offset,
    output logic [XLEN-1:0]        out_pc,
    output logic [CNT_W-1:0]       stall_count
);
    // Headroom of one: a held load can issue while another is accepted at MAX_PENDING-1
    localparam int PCW = $clog2(MAX_PENDING + 2);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                   decRegWe, decDataWe, decRegSelect;
    logic                   decRs1Read, decRs2Read, decIsLoad;
    ctrBranch               decBranchCtr;
    ctrALU                  decAluCtr;
    regAddr                 decRs1, decRs2, decRd, decRegB;
    logic signed [XLEN-1:0] decOffset;

    logic [31:0]            pending;
    logic [PCW-1:0]         pendCnt;
    logic                   pendFull;
    logic                   heldLoad, hazard, accept, issue, stall;

    logic                   vld_p1;
    logic                   regWe_p1, dataWe_p1, regSelect_p1, isLoad_p1;
    ctrBranch               branchCtr_p1;
    ctrALU                  aluCtr_p1;
    regAddr                 regA_p1, regB_p1, rd_p1;
    logic signed [XLEN-1:0] offset_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [CNT_W-1:0]       stallCnt;

    Decoder #(.XLEN(XLEN)) decoder (
        .insn      (in_insn),
        .regWe     (decRegWe),
        .dataWe    (decDataWe),
        .regSelect (decRegSelect),
        .branchCtr (decBranchCtr),
        .aluCtr    (decAluCtr),
        .rs1       (decRs1),
        .rs2       (decRs2),
        .rd        (decRd),
        .offset    (decOffset),
        .rs1Read   (decRs1Read),
        .rs2Read   (decRs2Read),
        .isLoad    (decIsLoad)
    );

    // Second operand field: rd for I/load-type encodings (insn[5]=0), rs2 otherwise
    Mux #(.W(5)) regBMux (
        .a   (decRd),
        .b   (decRs2),
        .sel (in_insn[5]),
        .y   (decRegB)
    );

    load_scoreboard #(.MAX_PENDING(MAX_PENDING), .PCW(PCW)) scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issueLoad (issue && isLoad_p1),
        .issueRd   (rd_p1),
        .wbValid   (wb_valid),
        .wbRd      (wb_rd),
        .pending   (pending),
        .pendCnt   (pendCnt),
        .full      (pendFull)
    );

    // Hazard detection and handshake; in_ready is held low throughout reset
    always_comb begin
        heldLoad = vld_p1 && isLoad_p1;
        hazard   = (decRs1Read && (decRs1 != '0) &&
                    (pending[decRs1] || (heldLoad && (decRs1 == rd_p1)))) ||
                   (decRs2Read && (decRs2 != '0) &&
                    (pending[decRs2] || (heldLoad && (decRs2 == rd_p1))));
        in_ready = rst && (flush ||
                   (!hazard && !(vld_p1 && !out_ready) && !(decIsLoad && pendFull)));
        accept   = in_valid && in_ready && !flush;
        issue    = vld_p1 && out_ready;
        stall    = in_valid && !in_ready && !flush;
    end

    // ---- stage boundary: decode -> EX (bundle valid) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (issue) begin
            vld_p1 <= 1'b0;
        end
    end

    // Bundle fields load only on accept, so they stay frozen under back-pressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWe_p1     <= 1'b0;
            dataWe_p1    <= 1'b0;
            regSelect_p1 <= 1'b0;
            isLoad_p1    <= 1'b0;
            branchCtr_p1 <= '0;
            aluCtr_p1    <= '0;
            regA_p1      <= '0;
            regB_p1      <= '0;
            rd_p1        <= '0;
            offset_p1    <= '0;
            pc_p1        <= '0;
        end else if (accept) begin
            regWe_p1     <= decRegWe;
            dataWe_p1    <= decDataWe;
            regSelect_p1 <= decRegSelect;
            isLoad_p1    <= decIsLoad;
            branchCtr_p1 <= decBranchCtr;
            aluCtr_p1    <= decAluCtr;
            regA_p1      <= decRs1;
            regB_p1      <= decRegB;
            rd_p1        <= decRd;
            offset_p1    <= decOffset;
            pc_p1        <= in_pc;
        end
    end

    // Saturating count of cycles where fetch offered an instruction we refused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (stall) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    assign out_valid     = vld_p1;
    assign out_regWe     = regWe_p1;
    assign out_dataWe    = dataWe_p1;
    assign out_regSelect = regSelect_p1;
    assign out_branchCtr = branchCtr_p1;
    assign out_aluCtr    = aluCtr_p1;
    assign out_regA      = regA_p1;
    assign out_regB      = regB_p1;
    assign out_rd        = rd_p1;
    assign out_offset    = offset_p1;
    assign out_pc        = pc_p1;
    assign stall_count   = stallCnt;

endmodule
